// File: rtl/pack_bit_framer.sv
// Serial framer: reads a buffered packet bit by bit, prepends a fixed preamble and
// emits one bit per symbol strobe. Define PACK_FRAMER_SCRAMBLE_EN to PRBS15-scramble payload bits.
module pack_bit_framer #(
    parameter int                         SIZE_BIT_PACK    = 1976,
    parameter int                         SIZE_ADDR_OUTPUT = $clog2(SIZE_BIT_PACK),
    parameter int                         SISE_PREAMBLE    = 32,
    parameter logic [SISE_PREAMBLE-1:0]   PREAMBLE_WORD    = 32'h1ACF_FC1D,
    parameter logic                       IDLE_BIT         = 1'b0
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_pack_ready,
    output logic [SIZE_ADDR_OUTPUT:0]     o_addr_pack_out,
    input  logic                          i_pack_bit,
    input  logic                          i_strobe,
    output logic                          o_bit,
    output logic                          o_valid,
    output logic                          o_sof,
    output logic                          o_pack_done
);

    localparam int AW = SIZE_ADDR_OUTPUT + 1;
    localparam int IW = (SISE_PREAMBLE > 1) ? $clog2(SISE_PREAMBLE) : 1;
    localparam int PW = $clog2(SISE_PREAMBLE) + 1;

    localparam logic [AW-1:0] LAST_ADDR    = AW'(SIZE_BIT_PACK - 1);
    localparam logic [PW-1:0] PRE_LAST_CNT = PW'(SISE_PREAMBLE - 1);
    localparam logic [IW-1:0] PRE_MSB_IDX  = IW'(SISE_PREAMBLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        PAY  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [PW-1:0]   pre_cnt_q, pre_cnt_d;
    logic            bit_q, bit_d;
    logic            valid_q, valid_d;
    logic            sof_q, sof_d;
    logic            done_q, done_d;
    logic [IW-1:0]   pre_idx;
    logic            pay_bit;

    assign pre_idx = PRE_MSB_IDX - pre_cnt_q[IW-1:0];

`ifdef PACK_FRAMER_SCRAMBLE_EN
    localparam logic [14:0] SCR_SEED = 15'h6000;

    logic [14:0] scr_q, scr_d, scr_cur;
    logic        scr_f;

    // Address 0 marks the first payload bit, so the seed is applied combinationally there.
    always_comb begin
        scr_cur = (addr_q == '0) ? SCR_SEED : scr_q;
        scr_f   = scr_cur[14] ^ scr_cur[13];
        pay_bit = i_pack_bit ^ scr_f;
        scr_d   = scr_q;
        if ((state_q == PAY) && i_strobe) begin
            scr_d = {scr_cur[13:0], scr_f};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            scr_q <= SCR_SEED;
        end else begin
            scr_q <= scr_d;
        end
    end
`else
    assign pay_bit = i_pack_bit;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pre_cnt_d = pre_cnt_q;
        bit_d     = bit_q;
        valid_d   = valid_q;
        sof_d     = 1'b0;
        done_d    = 1'b0;

        if (i_strobe) begin
            unique case (state_q)
                IDLE: begin
                    if (i_pack_ready) begin
                        bit_d     = PREAMBLE_WORD[SISE_PREAMBLE-1];
                        valid_d   = 1'b1;
                        sof_d     = 1'b1;
                        pre_cnt_d = PW'(1);
                        state_d   = PRE;
                    end else begin
                        bit_d   = IDLE_BIT;
                        valid_d = 1'b0;
                    end
                end
                PRE: begin
                    // A zero count here only happens on a back-to-back frame start.
                    bit_d   = PREAMBLE_WORD[pre_idx];
                    valid_d = 1'b1;
                    sof_d   = (pre_cnt_q == '0);
                    if (pre_cnt_q == PRE_LAST_CNT) begin
                        pre_cnt_d = '0;
                        state_d   = PAY;
                    end else begin
                        pre_cnt_d = pre_cnt_q + PW'(1);
                    end
                end
                PAY: begin
                    bit_d   = pay_bit;
                    valid_d = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        done_d  = 1'b1;
                        state_d = i_pack_ready ? PRE : IDLE;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            pre_cnt_q <= '0;
            bit_q     <= IDLE_BIT;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pre_cnt_q <= pre_cnt_d;
            bit_q     <= bit_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            done_q    <= done_d;
        end
    end

    assign o_addr_pack_out = addr_q;
    assign o_bit           = bit_q;
    assign o_valid         = valid_q;
    assign o_sof           = sof_q;
    assign o_pack_done     = done_q;

endmodule

// File: tb/tb_pack_bit_framer.sv
// Directed bench for pack_bit_framer: idle, single frame, back-to-back frames,
// mid-frame reset and ready drop; scrambler check when PACK_FRAMER_SCRAMBLE_EN is defined.
module tb_pack_bit_framer;

    localparam int NB = 1976;
    localparam int NP = 32;
    localparam int AW = $clog2(NB) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_pack_ready = 1'b0;
    logic [AW-1:0] o_addr_pack_out;
    logic          i_pack_bit = 1'b0;
    logic          i_strobe = 1'b0;
    logic          o_bit;
    logic          o_valid;
    logic          o_sof;
    logic          o_pack_done;

    logic [31:0]   pre_w = 32'h1ACFFC1D;
    logic          zero_pkt = 1'b0;
    int            checks = 0;
    int            failures = 0;
    int            done_cnt = 0;

    pack_bit_framer dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_pack_ready    (i_pack_ready),
        .o_addr_pack_out (o_addr_pack_out),
        .i_pack_bit      (i_pack_bit),
        .i_strobe        (i_strobe),
        .o_bit           (o_bit),
        .o_valid         (o_valid),
        .o_sof           (o_sof),
        .o_pack_done     (o_pack_done)
    );

    always #5 clk = ~clk;

    // Buffer model: 1-cycle read latency, bit i of the packet is i[0].
    always @(posedge clk) i_pack_bit <= zero_pkt ? 1'b0 : o_addr_pack_out[0];

    always @(negedge clk) if (o_pack_done) done_cnt++;

    task automatic strobe();
        @(negedge clk) i_strobe = 1'b1;
        @(negedge clk) i_strobe = 1'b0;
    endtask

    // Strobes through one frame; drops ready before strobe drop_at, stops before strobe stop_at.
    task automatic run_frame(input int drop_at, input int stop_at, input string tag);
        logic          exp_b;
        logic [AW-1:0] exp_a;
        logic          d;
        logic [14:0]   s;
        int            j;
        s = 15'h6000;
        for (int k = 0; k < NP + NB; k++) begin
            if (k == stop_at) return;
            if (k == drop_at) i_pack_ready = 1'b0;
            strobe();
            if (k < NP) begin
                exp_b = pre_w[31 - k];
                exp_a = '0;
            end else begin
                j = k - NP;
                d = zero_pkt ? 1'b0 : j[0];
`ifdef PACK_FRAMER_SCRAMBLE_EN
                if (j == 0) s = 15'h6000;
                d = d ^ (s[14] ^ s[13]);
                s = {s[13:0], s[14] ^ s[13]};
`endif
                exp_b = d;
                exp_a = (j == NB - 1) ? '0 : AW'(j + 1);
            end
            checks += 5;
            if (o_bit !== exp_b) begin
                failures++;
                $display("FAIL %s bit k=%0d got=%b exp=%b", tag, k, o_bit, exp_b);
            end
            if (o_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s valid k=%0d got=%b exp=1", tag, k, o_valid);
            end
            if (o_sof !== (k == 0)) begin
                failures++;
                $display("FAIL %s sof k=%0d got=%b exp=%b", tag, k, o_sof, (k == 0));
            end
            if (o_pack_done !== (k == NP + NB - 1)) begin
                failures++;
                $display("FAIL %s done k=%0d got=%b exp=%b", tag, k, o_pack_done, (k == NP + NB - 1));
            end
            if (o_addr_pack_out !== exp_a) begin
                failures++;
                $display("FAIL %s addr k=%0d got=%0d exp=%0d", tag, k, o_addr_pack_out, exp_a);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        strobe();
        checks += 3;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s valid got=%b exp=0", tag, o_valid);
        end
        if (o_bit !== 1'b0) begin
            failures++;
            $display("FAIL %s bit got=%b exp=0", tag, o_bit);
        end
        if (o_sof !== 1'b0) begin
            failures++;
            $display("FAIL %s sof got=%b exp=0", tag, o_sof);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (o_bit !== 1'b0) begin failures++; $display("FAIL rst_bit got=%b exp=0", o_bit); end
        if (o_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", o_valid); end
        if (o_sof !== 1'b0) begin failures++; $display("FAIL rst_sof got=%b exp=0", o_sof); end
        if (o_pack_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", o_pack_done); end
        if (o_addr_pack_out !== '0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", o_addr_pack_out); end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_idle("idle");
            checks++;
            if (o_addr_pack_out !== '0) begin
                failures++;
                $display("FAIL idle_addr got=%0d exp=0", o_addr_pack_out);
            end
        end
    endtask

    task automatic test_frame();
        int d0;
        d0 = done_cnt;
        i_pack_ready = 1'b1;
        run_frame(1, -1, "frame");
        check_idle("frame_tail");
        checks++;
        if (done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL frame_done_count got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        i_pack_ready = 1'b1;
        run_frame(-1, -1, "b2b_first");
        run_frame(5, -1, "b2b_second");
        check_idle("b2b_tail");
        checks++;
        if (done_cnt - d0 !== 2) begin
            failures++;
            $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        i_pack_ready = 1'b1;
        run_frame(2, NP + 501, "mid_pre");
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", o_valid); end
        if (o_bit !== 1'b0) begin failures++; $display("FAIL mid_rst_bit got=%b exp=0", o_bit); end
        if (o_addr_pack_out !== '0) begin failures++; $display("FAIL mid_rst_addr got=%0d exp=0", o_addr_pack_out); end
        if (o_pack_done !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b exp=0", o_pack_done); end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (done_cnt !== d0) begin
            failures++;
            $display("FAIL mid_rst_no_done got=%0d exp=%0d", done_cnt - d0, 0);
        end
        i_pack_ready = 1'b1;
        run_frame(1, -1, "mid_restart");
        check_idle("mid_tail");
        checks++;
        if (done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL mid_done_count got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_ready_drop();
        int d0;
        d0 = done_cnt;
        i_pack_ready = 1'b1;
        run_frame(10, -1, "drop");
        check_idle("drop_tail");
        checks++;
        if (done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL drop_done_count got=%0d exp=1", done_cnt - d0);
        end
    endtask

`ifdef PACK_FRAMER_SCRAMBLE_EN
    task automatic test_scramble();
        logic [2:0] exp3;
        exp3 = 3'b010;
        zero_pkt = 1'b1;
        i_pack_ready = 1'b1;
        for (int k = 0; k < NP; k++) begin
            strobe();
            if (k == 0) i_pack_ready = 1'b0;
            checks++;
            if (o_bit !== pre_w[31 - k]) begin
                failures++;
                $display("FAIL scr_pre k=%0d got=%b exp=%b", k, o_bit, pre_w[31 - k]);
            end
        end
        for (int j = 0; j < 3; j++) begin
            strobe();
            checks++;
            if (o_bit !== exp3[2 - j]) begin
                failures++;
                $display("FAIL scr_pay j=%0d got=%b exp=%b", j, o_bit, exp3[2 - j]);
            end
        end
        for (int j = 3; j < NB; j++) strobe();
        check_idle("scr_tail");
        zero_pkt = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_back_to_back();
        test_reset_mid();
        test_ready_drop();
`ifdef PACK_FRAMER_SCRAMBLE_EN
        test_scramble();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
